// File: rtl/power_acc_pkg.sv
// Shared types and constants for the power-sample block accumulator.
// Covers the base block and the optional peak tracker (POWER_ACC_PEAK_TRACK_EN).
package power_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int IN_W_DEF   = 20;
    localparam int MAX_SAMPLE = 810000;

    // A block of 2^n_log2 samples of in_w bits can never exceed in_w+n_log2 bits.
    function automatic int sum_width(input int in_w, input int n_log2);
        return in_w + n_log2;
    endfunction

endpackage

// File: rtl/peak_tracker.sv
// Running maximum over a block of samples. It is cleared at the end of each block,
// and the block maximum is kept in a result register. Built only with POWER_ACC_PEAK_TRACK_EN.
`ifdef POWER_ACC_PEAK_TRACK_EN
module peak_tracker #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         strobe,
    input  logic         last,
    input  logic [W-1:0] data,
    output logic [W-1:0] peak_o
);

    logic [W-1:0] pk_q;
    logic [W-1:0] peak_q;
    logic [W-1:0] max_d;

    always_comb begin
        max_d = (data > pk_q) ? data : pk_q;
    end

    // clear drops the running max but leaves the last published peak visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            pk_q   <= '0;
            peak_q <= '0;
        end else if (clear) begin
            pk_q   <= '0;
        end else if (strobe) begin
            if (last) begin
                peak_q <= max_d;
                pk_q   <= '0;
            end else begin
                pk_q   <= max_d;
            end
        end
    end

    assign peak_o = peak_q;

endmodule
`endif

// File: rtl/power_accumulator.sv
// Sums blocks of 2^N_LOG2 power samples and then holds the sum and the mean until the sink takes them.
// Optional block-maximum output: define POWER_ACC_PEAK_TRACK_EN.
module power_accumulator
    import power_acc_pkg::*;
#(
    parameter int  IN_W   = IN_W_DEF,
    parameter int  N_LOG2 = 4,
    localparam int SUM_W  = sum_width(IN_W, N_LOG2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  sum_out,
    output logic [IN_W-1:0]   mean_out
`ifdef POWER_ACC_PEAK_TRACK_EN
    ,
    output logic [IN_W-1:0]   peak_out
`endif
);

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;
    localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);

    acc_state_e        state_q;
    logic [SUM_W-1:0]  acc_q;
    logic [N_LOG2-1:0] cnt_q;
    logic [SUM_W-1:0]  sum_q;
    logic [IN_W-1:0]   mean_q;

    logic              accept_d;
    logic              last_d;
    logic [SUM_W-1:0]  acc_sum_d;

    always_comb begin
        accept_d  = in_valid && (state_q == ACCUM);
        last_d    = accept_d && (cnt_q == CNT_LAST);
        acc_sum_d = acc_q + SUM_W'(in_data);
    end

    // The handshake flags come straight from the state register, so neither one
    // has a combinational path from the other side of the interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            mean_q  <= '0;
        end else if (clear) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_d) begin
                        sum_q   <= acc_sum_d;
                        mean_q  <= acc_sum_d[SUM_W-1:N_LOG2];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (accept_d) begin
                        acc_q   <= acc_sum_d;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign sum_out   = sum_q;
    assign mean_out  = mean_q;

`ifdef POWER_ACC_PEAK_TRACK_EN
    peak_tracker #(
        .W      (IN_W)
    ) u_peak (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .strobe (accept_d),
        .last   (last_d),
        .data   (in_data),
        .peak_o (peak_out)
    );
`endif

endmodule

// File: tb/tb_power_accumulator.sv
// Directed test of power_accumulator with N_LOG2=2. It uses a vector table of 4-sample blocks and hand-written corner sequences.
module tb_power_accumulator;

    localparam int IN_W   = 20;
    localparam int N_LOG2 = 2;
    localparam int SUM_W  = IN_W + N_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  sum_out;
    logic [IN_W-1:0]   mean_out;
`ifdef POWER_ACC_PEAK_TRACK_EN
    logic [IN_W-1:0]   peak_out;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    power_accumulator #(
        .IN_W      (IN_W),
        .N_LOG2    (N_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .mean_out  (mean_out)
`ifdef POWER_ACC_PEAK_TRACK_EN
        ,
        .peak_out  (peak_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  s [4];
        bit               bub;
        logic [SUM_W-1:0] sum;
        logic [IN_W-1:0]  mean;
        logic [IN_W-1:0]  peak;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [SUM_W-1:0] esum,
                              input logic [IN_W-1:0] emean, input logic [IN_W-1:0] epeak);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " in_ready"},  32'(in_ready),  32'd0);
        chk({tag, " sum"},       32'(sum_out),   32'(esum));
        chk({tag, " mean"},      32'(mean_out),  32'(emean));
`ifdef POWER_ACC_PEAK_TRACK_EN
        chk({tag, " peak"},      32'(peak_out),  32'(epeak));
`else
        if (epeak == '1) $display("note: peak value unused");
`endif
    endtask

    // Drives 4 samples, one per cycle, or with an idle cycle between samples.
    // It returns at the negedge after the last accept, when the result must be visible.
    task automatic run_block(input logic [IN_W-1:0] s [4], input bit bub);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("in_ready before sample", 32'(in_ready), 32'd1);
            chk("out_valid during block", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = s[i];
            if (bub && i < 3) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 20'hABCDE;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        logic [IN_W-1:0] blk [4];

        vecs[0] = '{s: '{16, 256, 1296, 4096}, bub: 0, sum: 5664, mean: 1416, peak: 4096};
        vecs[1] = '{s: '{810000, 810000, 810000, 810000}, bub: 0, sum: 3240000, mean: 810000, peak: 810000};
        vecs[2] = '{s: '{16, 256, 1296, 4096}, bub: 1, sum: 5664, mean: 1416, peak: 4096};
        vecs[3] = '{s: '{1, 2, 3, 4}, bub: 0, sum: 10, mean: 2, peak: 4};
        vecs[4] = '{s: '{0, 0, 0, 0}, bub: 1, sum: 0, mean: 0, peak: 0};
        vecs[5] = '{s: '{4096, 1296, 256, 16}, bub: 0, sum: 5664, mean: 1416, peak: 4096};
        vecs[6] = '{s: '{1000000, 3, 1, 0}, bub: 0, sum: 1000004, mean: 250001, peak: 1000000};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset sum",       32'(sum_out),   32'd0);
        chk("reset mean",      32'(mean_out),  32'd0);
`ifdef POWER_ACC_PEAK_TRACK_EN
        chk("reset peak",      32'(peak_out),  32'd0);
`endif
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v].s, vecs[v].bub);
            chk_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].mean, vecs[v].peak);
            $display("vec %0d: sum=%0d mean=%0d", v, sum_out, mean_out);
            @(negedge clk);
            chk("after handshake out_valid", 32'(out_valid), 32'd0);
            chk("after handshake in_ready",  32'(in_ready),  32'd1);
        end

        // Backpressure: the result must hold and in_ready must stay low while extra samples are offered.
        out_ready = 1'b0;
        blk = '{10, 20, 30, 40};
        run_block(blk, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk_result("backpressure", 100, 25, 40);
            in_valid = 1'b1;
            in_data  = 999;
            @(negedge clk);
        end
        chk_result("backpressure end", 100, 25, 40);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready",  32'(in_ready),  32'd1);
        $display("backpressure: held sum=100 released");
        blk = '{1, 2, 3, 4};
        run_block(blk, 1'b0);
        chk_result("after bp", 10, 2, 4);
        @(negedge clk);

        // Clear mid-block; the sample that arrives in the same cycle as clear is dropped.
        blk = '{810000, 810000, 810000, 810000};
        run_block(blk, 1'b0);
        chk_result("pre-clear", 3240000, 810000, 810000);
        @(negedge clk);
        in_valid = 1'b1; in_data = 100;
        @(negedge clk);
        in_data = 200;
        @(negedge clk);
        in_data = 300; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        chk("clear keeps sum",  32'(sum_out),   32'd3240000);
        chk("clear out_valid",  32'(out_valid), 32'd0);
        blk = '{1, 2, 3, 4};
        run_block(blk, 1'b0);
        chk_result("after clear", 10, 2, 4);
        $display("clear mid-block: sum=%0d mean=%0d", sum_out, mean_out);
        @(negedge clk);

        // Clear while the result is held drops out_valid and keeps the result values.
        out_ready = 1'b0;
        blk = '{5, 6, 7, 8};
        run_block(blk, 1'b0);
        chk_result("pre-clear hold", 26, 6, 8);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear hold out_valid", 32'(out_valid), 32'd0);
        chk("clear hold in_ready",  32'(in_ready),  32'd1);
        chk("clear hold sum",       32'(sum_out),   32'd26);
        $display("clear in hold: sum=%0d", sum_out);

        // Reset while the result is held.
        blk = '{16, 256, 1296, 4096};
        run_block(blk, 1'b0);
        chk_result("pre-reset hold", 5664, 1416, 4096);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst hold out_valid", 32'(out_valid), 32'd0);
        chk("rst hold in_ready",  32'(in_ready),  32'd1);
        chk("rst hold sum",       32'(sum_out),   32'd0);
        chk("rst hold mean",      32'(mean_out),  32'd0);
        $display("reset in hold: out_valid=%0d sum=%0d", out_valid, sum_out);
        blk = '{4, 4, 4, 4};
        run_block(blk, 1'b1);
        chk_result("after rst", 16, 4, 4);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/power_accumulator.md
Name: power_accumulator

Overview:
- Downstream consumer of the 20-bit (2x)^4 power-sample stream produced by the pipelined multiplier stage.
- Accumulates a block of 2^N_LOG2 samples using a valid/ready input handshake.
- Presents block sum and block mean on a valid/ready output handshake. Holds the result under backpressure.
- Sits between the multiplier pipeline output register and the result sink or display logic.

Parameters:
- IN_W, 20, input sample width; max legal sample is 810000 ((2*15)^4).
- N_LOG2, 4, log2 of samples per block; legal range 1..8.
- SUM_W, IN_W+N_LOG2, accumulator and sum width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart; discards the partial block and any held result.
- in_valid  in  1  sample on in_data is valid.
- in_data  in  IN_W  power sample.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  sum_out and mean_out are valid.
- out_ready  in  1  sink accepts the result.
- sum_out  out  SUM_W  block sum.
- mean_out  out  IN_W  block mean = sum >> N_LOG2 (truncating).
- peak_out  out  IN_W  block maximum (present only with PEAK_TRACK_EN).

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, sum_out=0, mean_out=0, peak_out=0.
  - in_ready=1 in the first cycle after reset deasserts.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input accept: in_valid && in_ready at a clk edge.
  - acc <= acc + in_data; cnt <= cnt + 1 (N_LOG2-bit counter, wraps).
- ACCUM->HOLD: on accept when cnt == 2^N_LOG2-1.
  - sum_out <= acc + in_data; mean_out <= (acc + in_data) >> N_LOG2.
  - acc <= 0, cnt <= 0.
  - out_valid rises the cycle after the last accept (latency 1).
- HOLD: outputs stable while out_ready=0; in_data ignored.
- HOLD->ACCUM: on out_valid && out_ready.
  - out_valid <= 0; in_ready=1 next cycle.
  - No same-cycle accept of a new sample during the handshake.
- clear (priority below rst, above everything else):
  - state <= ACCUM, acc <= 0, cnt <= 0, out_valid <= 0.
  - A sample presented in the same cycle is discarded.
  - sum_out, mean_out, peak_out keep their last values.
- rst mid-block or mid-HOLD: full reset values; the result is lost.
- Arithmetic:
  - Unsigned throughout. No overflow is possible: 2^N_LOG2 * 810000 < 2^SUM_W.
  - Out-of-range inputs (>810000) are accumulated as-is and never flagged.
- in_ready is a pure function of state (no combinational path from in_valid).
- out_valid is registered.

Optional Feature:
- Macro: POWER_ACC_PEAK_TRACK_EN.
- Defined:
  - peak_out port exists.
  - Running max register pk: reset 0; on accept pk <= max(pk, in_data).
  - On the last accept, peak_out <= max(pk, in_data) and pk <= 0.
  - clear zeros pk.
- Undefined: no peak_out port and no pk register. Area and timing are identical to the base block.

Decomposition:
- Package power_acc_pkg:
  - state enum {ACCUM, HOLD}.
  - localparams IN_W_DEF=20, MAX_SAMPLE=810000.
  - function sum_width(in_w, n_log2).
- Natural sub-module: peak_tracker (running max with sync clear, strobe load). Instantiated only under POWER_ACC_PEAK_TRACK_EN.

Test Plan:
- Block sum and mean (N_LOG2=2, out_ready=1): feed 16, 256, 1296, 4096 back-to-back.
  - -> out_valid 1 cycle after 4096; sum_out=5664, mean_out=1416, peak_out=4096.
- Full-scale block: four samples of 810000.
  - -> sum_out=3240000 (22 bits, no wrap), mean_out=810000.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - -> outputs stable, in_ready=0, extra in_valid samples ignored.
  - -> out_ready=1 gives one handshake; next block starts from acc=0.
- Clear mid-block: accept 100, 200, then clear coinciding with in_valid=300, then feed 1, 2, 3, 4.
  - -> sum_out=10, mean_out=2 (truncated).
- Reset during HOLD: rst=1 for one cycle while out_valid=1.
  - -> out_valid=0, sum_out=0, in_ready=1 the next cycle.
- Bubbles: in_valid toggling 1,0,1,0 across a block of 16, 256, 1296, 4096.
  - -> same result as back-to-back; cnt advances only on accepts.
